// File: rtl/rtc_pkg.sv
// Shared types and default timing constants for the stopwatch button path.
package rtc_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD         = 3'd2,
    LONG_HELD    = 3'd3,
    RELEASE_WAIT = 3'd4
  } btn_state_t;

  // 10 ms debounce and 2 s long press at a 100 MHz system clock.
  localparam int RTC_DEBOUNCE_CYCLES   = 1_000_000;
  localparam int RTC_LONG_PRESS_CYCLES = 200_000_000;

endpackage

// File: rtl/rtc_button_conditioner_if.sv
// Button pad input and conditioned outputs, grouped as one bundle.
interface rtc_button_conditioner_if;

  logic i_button;
  logic o_level;
  logic o_press_pulse;
  logic o_long_press;
  logic o_short_release;
  logic o_release_pulse;

  // Board / upper layer side: drives the pad, consumes the events.
  modport master (
    output i_button,
    input  o_level,
    input  o_press_pulse,
    input  o_long_press,
    input  o_short_release,
    input  o_release_pulse
  );

  // Conditioner side.
  modport slave (
    input  i_button,
    output o_level,
    output o_press_pulse,
    output o_long_press,
    output o_short_release,
    output o_release_pulse
  );

endinterface

// File: rtl/rtc_synchronizer.sv
// Multi-flop synchroniser for an asynchronous pad input; resets to 0.
module rtc_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  // Shift the pad value through the flop chain, oldest bit is the synced sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/rtc_button_conditioner.sv
// Synchronises, debounces and classifies the start/stop push-button.
// Emits the debounced level plus press, long-press and release events.
module rtc_button_conditioner
  import rtc_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = RTC_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = RTC_LONG_PRESS_CYCLES
) (
  input logic                     i_sclk,
  input logic                     i_reset_n,
  rtc_button_conditioner_if.slave btn
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

  // Counters stop at their threshold so they can never wrap.
  function automatic logic [DB_W-1:0] db_sat_inc(input logic [DB_W-1:0] v);
    return (v == DB_MAX) ? v : v + DB_W'(1);
  endfunction

  function automatic logic [LP_W-1:0] lp_sat_inc(input logic [LP_W-1:0] v);
    return (v == LP_MAX) ? v : v + LP_W'(1);
  endfunction

  logic            s;
  btn_state_t      state_q, state_d;
  logic [DB_W-1:0] db_q, db_d, db_inc;
  logic [LP_W-1:0] lp_q, lp_d, lp_inc;
  logic            fired_q, fired_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            long_q, long_d;
  logic            short_q, short_d;
  logic            rel_q, rel_d;

  rtc_synchronizer #(
    .STAGES   (SYNC_STAGES)
  ) u_sync (
    .clk      (i_sclk),
    .rst_n    (i_reset_n),
    .async_in (btn.i_button),
    .sync_out (s)
  );

  // Next-state, counter and event decode from the synced sample.
  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    lp_d    = lp_q;
    fired_d = fired_q;
    level_d = level_q;
    press_d = 1'b0;
    long_d  = 1'b0;
    short_d = 1'b0;
    rel_d   = 1'b0;
    db_inc  = db_sat_inc(db_q);
    lp_inc  = lp_sat_inc(lp_q);
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          db_d    = DB_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          db_d    = '0;
        end else begin
          db_d = db_inc;
          if (db_inc == DB_MAX) begin
            state_d = HELD;
            level_d = 1'b1;
            press_d = 1'b1;
            lp_d    = '0;
            fired_d = 1'b0;
          end
        end
      end
      HELD: begin
        // Hold time accrues on every HELD cycle; a threshold reached on a
        // bounce cycle fires on the first stable-high cycle after it.
        lp_d = lp_inc;
        if (!s) begin
          state_d = RELEASE_WAIT;
          db_d    = DB_ONE;
        end else if (lp_inc == LP_MAX) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
          fired_d = 1'b1;
        end
      end
      LONG_HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          db_d    = DB_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = fired_q ? LONG_HELD : HELD;
        end else begin
          db_d = db_inc;
          if (db_inc == DB_MAX) begin
            state_d = IDLE;
            db_d    = '0;
            level_d = 1'b0;
            rel_d   = 1'b1;
            short_d = !fired_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        db_d    = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      db_q    <= '0;
      lp_q    <= '0;
      fired_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      long_q  <= 1'b0;
      short_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      lp_q    <= lp_d;
      fired_q <= fired_d;
      level_q <= level_d;
      press_q <= press_d;
      long_q  <= long_d;
      short_q <= short_d;
      rel_q   <= rel_d;
    end
  end

  assign btn.o_level         = level_q;
  assign btn.o_press_pulse   = press_q;
  assign btn.o_long_press    = long_q;
  assign btn.o_short_release = short_q;
  assign btn.o_release_pulse = rel_q;

endmodule

// File: tb/tb_rtc_button_conditioner.sv
// Bench for rtc_button_conditioner: press-profile table, hand sequences for
// bounce / reset corners, and random stimulus against a run-length model.
module tb_rtc_button_conditioner;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int LP   = 20;
  localparam int PATN = 1100;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  rtc_button_conditioner_if bif();

  rtc_button_conditioner #(
    .SYNC_STAGES       (SYNC),
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP)
  ) dut (
    .i_sclk    (clk),
    .i_reset_n (rst_n),
    .btn       (bif)
  );

  always #5 clk = ~clk;

  // Reference model: a synced sample differing from the accepted level
  // extends a run; DB such samples in a row flip the level. Hold time
  // counts cycles the level is high with no run pending.
  typedef struct {
    bit [SYNC-1:0] dl;
    bit level;
    int run;
    int held;
    bit fired;
    bit press;
    bit lng;
    bit rel;
    bit shrt;
  } m_t;

  m_t m;

  function automatic m_t model_step(m_t c, bit b);
    m_t n = c;
    bit s;
    bit held_ok;
    n.press = 1'b0;
    n.lng   = 1'b0;
    n.rel   = 1'b0;
    n.shrt  = 1'b0;
    s = c.dl[SYNC-1];
    n.dl = {c.dl[SYNC-2:0], b};
    held_ok = c.level && (c.run == 0) && !c.fired;
    n.run = (s != c.level) ? c.run + 1 : 0;
    if (held_ok) begin
      n.held = (c.held < LP) ? c.held + 1 : LP;
      if (s && n.held == LP) begin
        n.lng   = 1'b1;
        n.fired = 1'b1;
      end
    end
    if (n.run == DB) begin
      n.run = 0;
      if (!c.level) begin
        n.level = 1'b1;
        n.press = 1'b1;
        n.held  = 0;
        n.fired = 1'b0;
      end else begin
        n.level = 1'b0;
        n.rel   = 1'b1;
        n.shrt  = !n.fired;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= model_step(m, bif.i_button);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-profile observations.
  bit pat [0:PATN];
  int press_cnt, press_at, lng_cnt, lng_at, rel_cnt, rel_at, short_cnt, lvl_hi;

  task automatic set_hold(input int len);
    for (int i = 0; i <= PATN; i++) pat[i] = (i >= 1 && i <= len);
  endtask

  // Edge k samples pat[k]; offsets are edge numbers counted from the start.
  task automatic run(input int win);
    press_cnt = 0; press_at = -1; lng_cnt = 0; lng_at = -1;
    rel_cnt = 0; rel_at = -1; short_cnt = 0; lvl_hi = 0;
    bif.i_button = pat[1];
    for (int k = 1; k <= win; k++) begin
      tick();
      if (bif.o_press_pulse)   begin press_cnt++; if (press_at < 0) press_at = k; end
      if (bif.o_long_press)    begin lng_cnt++;   if (lng_at < 0)   lng_at = k;   end
      if (bif.o_release_pulse) begin rel_cnt++;   if (rel_at < 0)   rel_at = k;   end
      if (bif.o_short_release) short_cnt++;
      if (bif.o_level) lvl_hi++;
      bif.i_button = pat[k+1];
    end
  endtask

  task automatic expect_profile(input string tag, input int e_press, input int e_press_at,
                                input int e_lng, input int e_lng_at, input int e_rel_at,
                                input int e_short, input int e_hi);
    check({tag, " press_cnt"}, press_cnt, e_press);
    check({tag, " long_cnt"},  lng_cnt,   e_lng);
    check({tag, " rel_cnt"},   rel_cnt,   e_press);
    check({tag, " short_cnt"}, short_cnt, e_short);
    check({tag, " level_hi"},  lvl_hi,    e_hi);
    if (e_press != 0) begin
      check({tag, " press_at"}, press_at, e_press_at);
      check({tag, " rel_at"},   rel_at,   e_rel_at);
    end
    if (e_lng != 0) check({tag, " long_at"}, lng_at, e_lng_at);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " o_level"},         bif.o_level,         0);
    check({tag, " o_press_pulse"},   bif.o_press_pulse,   0);
    check({tag, " o_long_press"},    bif.o_long_press,    0);
    check({tag, " o_short_release"}, bif.o_short_release, 0);
    check({tag, " o_release_pulse"}, bif.o_release_pulse, 0);
  endtask

  typedef struct {
    int hold;
    int press;
    int press_at;
    int lng;
    int lng_at;
    int rel_at;
    int shrt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int found;
    bit lvl;
    int rem;
    logic [4:0] dv, mv;

    // hold length -> press count/offset, long count/offset, release offset, short count
    vecs[0] = '{1,  0, 0, 0, 0,  0, 0};
    vecs[1] = '{3,  0, 0, 0, 0,  0, 0};
    vecs[2] = '{4,  1, 6, 0, 0, 10, 1};
    vecs[3] = '{5,  1, 6, 0, 0, 11, 1};
    vecs[4] = '{10, 1, 6, 0, 0, 16, 1};
    vecs[5] = '{15, 1, 6, 0, 0, 21, 1};
    vecs[6] = '{23, 1, 6, 0, 0, 29, 1};
    vecs[7] = '{24, 1, 6, 1, 26, 30, 0};
    vecs[8] = '{30, 1, 6, 1, 26, 36, 0};
    vecs[9] = '{50, 1, 6, 1, 26, 56, 0};

    rst_n = 1'b0;
    bif.i_button = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 10; i++) begin
      set_hold(vecs[i].hold);
      run(vecs[i].hold + 40);
      expect_profile($sformatf("hold%0d", vecs[i].hold), vecs[i].press, vecs[i].press_at,
                     vecs[i].lng, vecs[i].lng_at, vecs[i].rel_at, vecs[i].shrt,
                     vecs[i].press ? vecs[i].hold : 0);
    end

    // 3-cycle highs separated by 1-cycle lows never complete a debounce run.
    for (int i = 0; i <= PATN; i++) pat[i] = (i >= 1 && i <= 20 && (i % 4) != 0);
    run(40);
    expect_profile("bounce", 0, 0, 0, 0, 0, 0, 0);

    // Two-cycle low while held: level stays high, long press slips by 2.
    set_hold(50);
    pat[11] = 1'b0;
    pat[12] = 1'b0;
    run(90);
    expect_profile("held_bounce", 1, 6, 1, 28, 56, 0, 50);

    // Very long hold: a single long press, no counter wrap.
    set_hold(1000);
    run(1030);
    expect_profile("hold1000", 1, 6, 1, 26, 1006, 0, 1000);

    // Reset in the middle of a held press, button kept high across it.
    bif.i_button = 1'b1;
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (bif.o_level) found = 1;
    end
    check("midreset reach_held", found, 1);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset immediate");
    tick();
    tick();
    check_all_zero("midreset held");
    #2 rst_n = 1'b1;
    found = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bif.o_press_pulse && found < 0) found = k;
    end
    check("midreset repress_at", found, 6);
    bif.i_button = 1'b0;
    repeat (15) tick();
    check_all_zero("midreset settled");

    // Random run lengths, compared cycle by cycle with the model.
    lvl = 1'b0;
    rem = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rem == 0) begin
        lvl = ~lvl;
        rem = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 40) : $urandom_range(1, 6);
      end
      bif.i_button = lvl;
      rem--;
      tick();
      dv = {bif.o_level, bif.o_press_pulse, bif.o_long_press, bif.o_short_release, bif.o_release_pulse};
      mv = {m.level, m.press, m.lng, m.shrt, m.rel};
      check($sformatf("random c%0d {lvl,prs,lng,shr,rel}", c), {27'd0, dv}, {27'd0, mv});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
